// File: rtl/fpu_ss_pkg.sv
// ============================================================================
//  Module      : fpu_ss_pkg
//  Description : Shared types and constants for the FPU subsystem compressed
//                instruction path (predecoder request/response and the
//                buffer entry queued ahead of the predecoder).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_ss_pkg;

    // Default number of queue entries in front of the output register
    localparam int unsigned COMP_BUF_DEPTH_DEFAULT = 2;

    // Width of the id field stored in a buffer entry; instances must use an
    // ID_WIDTH no wider than this
    localparam int unsigned COMP_BUF_ID_W = 4;

    // Request to the combinational compressed predecoder
    typedef struct packed {
        logic [15:0] comp_instr;
    } comp_prd_req_t;

    // Response from the combinational compressed predecoder
    typedef struct packed {
        logic        accept;
        logic [31:0] decomp_instr;
    } comp_prd_rsp_t;

    // One queued compressed request
    typedef struct packed {
        logic [15:0]              instr;
        logic [COMP_BUF_ID_W-1:0] id;
    } comp_buf_entry_t;

endpackage

`default_nettype wire

// File: rtl/fpu_ss_comp_fifo.sv
// ============================================================================
//  Module      : fpu_ss_comp_fifo
//  Description : Small synchronous FIFO of comp_buf_entry_t with full/empty
//                flags and a synchronous flush. DEPTH must be a power of two;
//                DEPTH=1 collapses to a single valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_ss_comp_fifo
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DEPTH = COMP_BUF_DEPTH_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  comp_buf_entry_t data_i,
    input  logic            pop_i,
    output comp_buf_entry_t data_o,
    output logic            full_o,
    output logic            empty_o
);

    if (DEPTH == 1) begin : g_single

        logic            r_valid;
        comp_buf_entry_t r_data;

        // Occupancy flag; the parent never pushes while full, so push wins
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_valid <= 1'b0;
            end else if (flush_i) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= push_i | (r_valid & ~pop_i);
            end
        end

        // Payload storage; contents are meaningless while r_valid is low
        always_ff @(posedge clk_i) begin
            if (push_i) begin
                r_data <= data_i;
            end
        end

        assign data_o  = r_data;
        assign full_o  = r_valid;
        assign empty_o = ~r_valid;

    end else begin : g_multi

        localparam int unsigned PTR_W = $clog2(DEPTH);
        localparam int unsigned CNT_W = PTR_W + 1;

        logic [PTR_W-1:0] r_wptr;
        logic [PTR_W-1:0] r_rptr;
        logic [CNT_W-1:0] r_count;
        comp_buf_entry_t  r_mem [DEPTH];

        // Pointers wrap naturally at DEPTH since DEPTH is a power of two
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else if (flush_i) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (push_i) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (pop_i) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                if (push_i && !pop_i) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!push_i && pop_i) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end

        // Entry storage written at the tail
        always_ff @(posedge clk_i) begin
            if (push_i) begin
                r_mem[r_wptr] <= data_i;
            end
        end

        assign data_o  = r_mem[r_rptr];
        assign full_o  = (r_count == CNT_W'(DEPTH));
        assign empty_o = (r_count == '0);

    end

endmodule

`default_nettype wire

// File: rtl/fpu_ss_compressed_buffer.sv
// ============================================================================
//  Module      : fpu_ss_compressed_buffer
//  Description : Order-preserving buffer between the core's compressed
//                offload channel and the compressed predecoder. Requests are
//                queued in a FIFO, the head feeds the predecoder and the
//                result is held in an output register until consumed.
//                Optional feature macro: FPU_SS_COMP_REJ_CNT_EN adds the
//                saturating rejected-instruction counter rej_cnt_o.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_ss_compressed_buffer
    import fpu_ss_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = COMP_BUF_DEPTH_DEFAULT,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                c_valid_i,
    output logic                c_ready_o,
    input  logic [15:0]         c_instr_i,
    input  logic [ID_WIDTH-1:0] c_id_i,
    output comp_prd_req_t       prd_req_o,
    input  comp_prd_rsp_t       prd_rsp_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic                rsp_accept_o,
    output logic [31:0]         rsp_instr_o,
`ifdef FPU_SS_COMP_REJ_CNT_EN
    output logic [15:0]         rej_cnt_o,
`endif
    output logic [ID_WIDTH-1:0] rsp_id_o
);

    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_fifo_push;
    logic            w_fifo_pop;
    logic            w_push;
    logic            w_bypass;
    logic            w_out_loadable;
    logic            w_load;
    logic [ID_WIDTH-1:0] w_sel_id;
    comp_buf_entry_t w_in_entry;
    comp_buf_entry_t w_head;

    logic                r_rsp_valid;
    logic                r_rsp_accept;
    logic [31:0]         r_rsp_instr;
    logic [ID_WIDTH-1:0] r_rsp_id;

    // Handshake and routing decisions; ready uses only the registered full
    // flag so a pop on a full FIFO cannot open the door in the same cycle
    always_comb begin
        w_out_loadable = ~r_rsp_valid | rsp_ready_i;
        c_ready_o      = ~w_fifo_full & ~flush_i;
        w_push         = c_valid_i & c_ready_o;
        w_bypass       = w_push & w_fifo_empty & w_out_loadable;
        w_fifo_push    = w_push & ~w_bypass;
        w_fifo_pop     = w_out_loadable & ~w_fifo_empty & ~flush_i;
        w_load         = w_fifo_pop | w_bypass;
    end

    // Incoming request packed for the queue
    always_comb begin
        w_in_entry       = '0;
        w_in_entry.instr = c_instr_i;
        w_in_entry.id    = COMP_BUF_ID_W'(c_id_i);
    end

    // Predecoder sees the live request only when nothing is queued ahead
    always_comb begin
        prd_req_o            = '0;
        prd_req_o.comp_instr = w_fifo_empty ? c_instr_i : w_head.instr;
        w_sel_id             = w_fifo_empty ? c_id_i : w_head.id[ID_WIDTH-1:0];
    end

    fpu_ss_comp_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (w_fifo_push),
        .data_i  (w_in_entry),
        .pop_i   (w_fifo_pop),
        .data_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Output register holding the predecoder result until it is consumed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_accept <= 1'b0;
            r_rsp_instr  <= '0;
            r_rsp_id     <= '0;
        end else if (flush_i) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_accept <= 1'b0;
            r_rsp_instr  <= '0;
            r_rsp_id     <= '0;
        end else if (w_out_loadable) begin
            r_rsp_valid <= w_load;
            if (w_load) begin
                r_rsp_accept <= prd_rsp_i.accept;
                r_rsp_instr  <= prd_rsp_i.decomp_instr;
                r_rsp_id     <= w_sel_id;
            end
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_accept_o = r_rsp_accept;
    assign rsp_instr_o  = r_rsp_instr;
    assign rsp_id_o     = r_rsp_id;

`ifdef FPU_SS_COMP_REJ_CNT_EN
    logic [15:0] r_rej_cnt;

    // Count consumed rejections; a handshake coinciding with flush is void
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rej_cnt <= '0;
        end else if (r_rsp_valid && rsp_ready_i && !r_rsp_accept && !flush_i
                     && (r_rej_cnt != 16'hFFFF)) begin
            r_rej_cnt <= r_rej_cnt + 16'd1;
        end
    end

    assign rej_cnt_o = r_rej_cnt;
`endif

endmodule

`default_nettype wire
